// File: rtl/multi_cycle_controller.sv
// Multi-cycle MIPS-subset control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects and write enables from the current state.
module multi_cycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       MemToReg,
  output logic       RegDest,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       JAL,
  output logic       JR,
  output logic       illegal,
  output logic       instr_done,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUControl,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_ALU_WB   = 4'd7,
    S_EXEC_I   = 4'd8,
    S_ADDI_WB  = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JUMPR    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  state_t     cur, nxt;
  logic       r_legal;
  logic [2:0] r_alu;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur <= S_FETCH;
    else       cur <= nxt;
  end

  assign state = cur;

  always_comb begin
    r_legal = 1'b1;
    r_alu   = 3'b010;
    case (Funct)
      6'b100000: r_alu = 3'b010;
      6'b100010: r_alu = 3'b110;
      6'b100100: r_alu = 3'b000;
      6'b100101: r_alu = 3'b001;
      6'b101010: r_alu = 3'b111;
      6'b000000: r_alu = 3'b011;
      6'b000010: r_alu = 3'b100;
      FN_JR:     r_alu = 3'b010;
      default:   r_legal = 1'b0;
    endcase
  end

  always_comb begin
    nxt        = S_FETCH;
    PCWrite    = 1'b0;
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    MemToReg   = 1'b0;
    RegDest    = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    JAL        = 1'b0;
    JR         = 1'b0;
    illegal    = 1'b0;
    instr_done = 1'b0;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
    ALUControl = 3'b010;
    case (cur)
      S_FETCH: begin
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        nxt     = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (Opcode)
          OP_RTYPE: begin
            if (!r_legal)            illegal = 1'b1;
            else if (Funct == FN_JR) nxt = S_JUMPR;
            else                     nxt = S_EXEC_R;
          end
          OP_ADDI:       nxt = S_EXEC_I;
          OP_LW, OP_SW:  nxt = S_MEM_ADDR;
          OP_BEQ, OP_BNE: nxt = S_BRANCH;
          OP_JAL:        nxt = S_JUMP;
          default:       illegal = 1'b1;
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nxt     = (Opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        IorD = 1'b1;
        nxt  = mem_ready ? S_MEM_WB : S_MEM_RD;
      end
      S_MEM_WB: begin
        RegWrite   = 1'b1;
        MemToReg   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) instr_done = 1'b1;
        else           nxt = S_MEM_WR;
      end
      S_EXEC_R: begin
        ALUSrcA    = 1'b1;
        ALUControl = r_alu;
        nxt        = S_ALU_WB;
      end
      S_ALU_WB: begin
        RegWrite   = 1'b1;
        RegDest    = 1'b1;
        instr_done = 1'b1;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nxt     = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = 3'b110;
        PCSrc      = 2'b01;
        PCWrite    = ((Opcode == OP_BEQ) & Zero) | ((Opcode == OP_BNE) & ~Zero);
        instr_done = 1'b1;
      end
      S_JUMP: begin
        PCSrc      = 2'b10;
        PCWrite    = 1'b1;
        RegWrite   = 1'b1;
        JAL        = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMPR: begin
        PCSrc      = 2'b11;
        PCWrite    = 1'b1;
        JR         = 1'b1;
        instr_done = 1'b1;
      end
      default: nxt = S_FETCH;
    endcase
    // The register already reads FETCH under reset; FETCH would otherwise echo mem_ready.
    if (reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Scoreboard bench: an instruction-level model pushes per-cycle expected outputs,
// a negedge monitor pops and compares them against the controller.
module tb_multi_cycle_controller;

  logic       clk = 1'b0;
  logic       reset, Zero, mem_ready;
  logic [5:0] Opcode, Funct;
  logic       PCWrite, IorD, IRWrite, MemWrite, MemToReg, RegDest, RegWrite;
  logic       ALUSrcA, JAL, JR, illegal, instr_done;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;

  multi_cycle_controller dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .IorD(IorD), .IRWrite(IRWrite),
    .MemWrite(MemWrite), .MemToReg(MemToReg), .RegDest(RegDest), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .JAL(JAL), .JR(JR), .illegal(illegal), .instr_done(instr_done),
    .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUControl(ALUControl), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pcw, iord, irw, memw, m2r, rdst, rw, srca, jal, jr, ill, done;
    logic [1:0] srcb, pcsrc;
    logic [2:0] aluc;
    logic [3:0] st;
  } outs_t;

  typedef enum int {C_ILL, C_RT, C_JR, C_ADDI, C_LW, C_SW, C_BEQ, C_BNE, C_JAL} cls_t;

  outs_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    n_cyc = 0;

  function automatic outs_t base(input int st);
    outs_t o = '0;
    o.aluc = 3'b010;
    o.st   = 4'(st);
    return o;
  endfunction

  function automatic cls_t classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000: begin
        if (fn == 6'b001000) return C_JR;
        if (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101,
                       6'b101010, 6'b000000, 6'b000010}) return C_RT;
        return C_ILL;
      end
      6'b001000: return C_ADDI;
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000100: return C_BEQ;
      6'b000101: return C_BNE;
      6'b000011: return C_JAL;
      default:   return C_ILL;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      6'b000000: return 3'b011;
      6'b000010: return 3'b100;
      default:   return 3'b010;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle of stimulus; called at posedge+1.
  task automatic step(input logic mr, input outs_t e);
    mem_ready = mr;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int wf, input int wm);
    outs_t e;
    cls_t  c = classify(op, fn);
    Opcode = op; Funct = fn; Zero = z;
    for (int i = 0; i < wf; i++) begin
      e = base(0); e.srcb = 2'b01; step(1'b0, e);
    end
    e = base(0); e.srcb = 2'b01; e.pcw = 1'b1; e.irw = 1'b1; step(1'b1, e);
    e = base(1); e.srcb = 2'b11;
    if (c == C_ILL) e.ill = 1'b1;
    step(1'($urandom_range(0, 1)), e);
    case (c)
      C_RT: begin
        e = base(6); e.srca = 1'b1; e.aluc = alu_of(fn); step(1'($urandom_range(0, 1)), e);
        e = base(7); e.rw = 1'b1; e.rdst = 1'b1; e.done = 1'b1; step(1'($urandom_range(0, 1)), e);
      end
      C_ADDI: begin
        e = base(8); e.srca = 1'b1; e.srcb = 2'b10; step(1'($urandom_range(0, 1)), e);
        e = base(9); e.rw = 1'b1; e.done = 1'b1; step(1'($urandom_range(0, 1)), e);
      end
      C_LW, C_SW: begin
        e = base(2); e.srca = 1'b1; e.srcb = 2'b10; step(1'($urandom_range(0, 1)), e);
        e = base(c == C_LW ? 3 : 5); e.iord = 1'b1; e.memw = (c == C_SW);
        for (int i = 0; i < wm; i++) step(1'b0, e);
        if (c == C_LW) begin
          step(1'b1, e);
          e = base(4); e.rw = 1'b1; e.m2r = 1'b1; e.done = 1'b1; step(1'($urandom_range(0, 1)), e);
        end else begin
          e.done = 1'b1; step(1'b1, e);
        end
      end
      C_BEQ, C_BNE: begin
        e = base(10); e.srca = 1'b1; e.aluc = 3'b110; e.pcsrc = 2'b01; e.done = 1'b1;
        e.pcw = (c == C_BEQ) ? z : !z;
        step(1'($urandom_range(0, 1)), e);
      end
      C_JAL: begin
        e = base(11); e.pcsrc = 2'b10; e.pcw = 1'b1; e.rw = 1'b1; e.jal = 1'b1; e.done = 1'b1;
        step(1'($urandom_range(0, 1)), e);
      end
      C_JR: begin
        e = base(12); e.pcsrc = 2'b11; e.pcw = 1'b1; e.jr = 1'b1; e.done = 1'b1;
        step(1'($urandom_range(0, 1)), e);
      end
      default: ;
    endcase
  endtask

  // Monitor: every cycle with a pending expectation is compared at the falling edge.
  initial begin
    outs_t act, e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {PCWrite, IorD, IRWrite, MemWrite, MemToReg, RegDest, RegWrite, ALUSrcA,
               JAL, JR, illegal, instr_done, ALUSrcB, PCSrc, ALUControl, state};
        n_cyc++;
        if (act !== e)
          $display("FAIL cycle%0d_st%0d: got state %0d outs %h, expected state %0d outs %h",
                   n_cyc, e.st, act.st, act, e.st, e);
        n_cmp++;
        if (act !== e) n_err++;
      end
    end
  end

  logic [5:0] legal_ops [7] = '{6'b000000, 6'b001000, 6'b100011, 6'b101011,
                                6'b000100, 6'b000101, 6'b000011};
  logic [5:0] r_fns [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                            6'b101010, 6'b000000, 6'b000010, 6'b001000};

  initial begin
    logic [5:0] op, fn;
    reset = 1'b0; mem_ready = 1'b1; Opcode = 6'b100011; Funct = '0; Zero = 1'b0;
    #1 reset = 1'b1;
    #3;
    check("reset_async_state", 32'(state), 32'd0);
    check("reset_wen", {28'd0, PCWrite, IRWrite, MemWrite, RegWrite}, 32'd0);
    repeat (2) @(negedge clk);
    check("reset_held_state", 32'(state), 32'd0);
    check("reset_held_wen", {28'd0, PCWrite, IRWrite, MemWrite, RegWrite}, 32'd0);
    mem_ready = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_reset_fetch", 32'(state), 32'd0);

    // Drive an SW into MEM_WR, then reset between edges.
    Opcode = 6'b101011; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 mem_ready = 1'b0;
    #2;
    check("sw_in_mem_wr", {27'd0, MemWrite, state}, {27'd0, 1'b1, 4'd5});
    #1 reset = 1'b1; mem_ready = 1'b1;
    #1;
    check("reset_mid_memwr_state", 32'(state), 32'd0);
    check("reset_mid_memwr_wen", {28'd0, PCWrite, IRWrite, MemWrite, RegWrite}, 32'd0);
    @(negedge clk);
    mem_ready = 1'b0;
    #2 reset = 1'b0;
    @(posedge clk); #1;
    check("resume_fetch", 32'(state), 32'd0);

    // Directed instructions from the verification list.
    run_instr(6'b000000, 6'b100000, 1'b0, 0, 0); // ADD
    run_instr(6'b100011, 6'b000000, 1'b0, 0, 2); // LW with 2 waits
    run_instr(6'b000100, 6'b000000, 1'b1, 0, 0); // BEQ taken
    run_instr(6'b000101, 6'b000000, 1'b1, 0, 0); // BNE not taken
    run_instr(6'b000011, 6'b000000, 1'b0, 0, 0); // JAL
    run_instr(6'b000000, 6'b001000, 1'b0, 0, 0); // JR
    run_instr(6'b111111, 6'b000000, 1'b0, 0, 0); // illegal opcode
    run_instr(6'b000000, 6'b111111, 1'b0, 1, 0); // illegal funct
    run_instr(6'b101011, 6'b000000, 1'b0, 2, 3); // SW with waits

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      else op = legal_ops[$urandom_range(0, 6)];
      if ($urandom_range(0, 7) == 0) fn = 6'($urandom);
      else fn = r_fns[$urandom_range(0, 7)];
      run_instr(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multi_cycle_controller.md
MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 The block SHALL have exactly one clock and one reset: reset is asynchronous and active-high.
REQ-002 Port clk  in  1  rising-edge clock for all state.
REQ-003 Port reset  in  1  asynchronous, active-high; forces FETCH.
REQ-004 Port Opcode  in  6  instr[31:26] from the instruction register; stable outside FETCH.
REQ-005 Port Funct  in  6  instr[5:0] from the instruction register.
REQ-006 Port Zero  in  1  ALU zero flag, same cycle.
REQ-007 Port mem_ready  in  1  memory access completes this cycle.
REQ-008 Outputs, all width 1: PCWrite, IorD, IRWrite, MemWrite, MemToReg, RegDest, RegWrite, ALUSrcA, JAL, JR, illegal, instr_done.
REQ-009 Outputs ALUSrcB[1:0] (00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2) and PCSrc[1:0] (00 ALU result, 01 ALUOut, 10 jump target, 11 register rs).
REQ-010 Output ALUControl[2:0]: 010 add, 110 sub, 000 and, 001 or, 111 slt, 011 sll, 100 srl.
REQ-011 Output state[3:0]: current state code, for observation.

Function
REQ-012 Supported instructions: R-type (Opcode 000000) ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010, SLL 000000, SRL 000010, JR 001000; ADDI 001000; BEQ 000100; BNE 000101; LW 100011; SW 101011; JAL 000011.
REQ-013 Outputs not listed for a state SHALL be 0; ALUControl defaults to 010.
REQ-014 FETCH(0): IorD=0, ALUSrcA=0, ALUSrcB=01, PCSrc=00; IRWrite=PCWrite=mem_ready; stay in FETCH while mem_ready=0, else go to DECODE.
REQ-015 DECODE(1): ALUSrcA=0, ALUSrcB=11, add; next state: R-type JR -> JUMPR, other legal R-type -> EXEC_R, ADDI -> EXEC_I, LW/SW -> MEM_ADDR, BEQ/BNE -> BRANCH, JAL -> JUMP.
REQ-016 DECODE with an unsupported Opcode, or an unsupported Funct under R-type, SHALL assert illegal for that cycle and go to FETCH with no register, memory, or PC write.
REQ-017 MEM_ADDR(2): ALUSrcA=1, ALUSrcB=10, add; LW -> MEM_RD, SW -> MEM_WR.
REQ-018 MEM_RD(3): IorD=1; wait while mem_ready=0, then go to MEM_WB.
REQ-019 MEM_WB(4): RegWrite=1, MemToReg=1, RegDest=0; go to FETCH.
REQ-020 MEM_WR(5): IorD=1, MemWrite=1; hold while mem_ready=0, then go to FETCH.
REQ-021 EXEC_R(6): ALUSrcA=1, ALUSrcB=00, ALUControl decoded from Funct per REQ-010; go to ALU_WB.
REQ-022 ALU_WB(7): RegWrite=1, RegDest=1, MemToReg=0; go to FETCH.
REQ-023 EXEC_I(8): ALUSrcA=1, ALUSrcB=10, add; go to ADDI_WB(9).
REQ-024 ADDI_WB(9): RegWrite=1, RegDest=0; go to FETCH.
REQ-025 BRANCH(10): ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01; PCWrite = (BEQ & Zero) | (BNE & !Zero), evaluated combinationally; go to FETCH.
REQ-026 JUMP(11): PCSrc=10, PCWrite=1, RegWrite=1, JAL=1; go to FETCH.
REQ-027 JUMPR(12): PCSrc=11, PCWrite=1, JR=1; go to FETCH.
REQ-028 Codes 13-15 SHALL go to FETCH on the next edge and drive defaults.
REQ-029 instr_done SHALL be 1 in the final cycle of each instruction (a cycle that transitions to FETCH, other than an illegal abort).
REQ-030 Latency with mem_ready=1: LW 5 cycles; SW, R-type, ADDI 4; BEQ/BNE, JAL, JR 3; each memory wait cycle adds 1.

Reset
REQ-031 While reset=1, state SHALL be FETCH (0) immediately, independent of clk, and all write enables (PCWrite, IRWrite, MemWrite, RegWrite) SHALL be 0.
REQ-032 Reset deasserted mid-instruction SHALL abandon that instruction; execution resumes with FETCH on the first clk edge after release.

Verification
REQ-033 ADD (Funct 100000), mem_ready=1 -> states 0,1,6,7; ALUControl=010 in state 6; RegWrite=RegDest=1 in state 7; instr_done in state 7.
REQ-034 LW, mem_ready=0 for 2 cycles in MEM_RD -> states 0,1,2,3,3,3,4; MemToReg=RegWrite=1 in state 4.
REQ-035 BEQ with Zero=1 -> PCWrite=1 and PCSrc=01 in state 10; BNE with Zero=1 -> PCWrite=0.
REQ-036 JAL -> state 11 with JAL=RegWrite=PCWrite=1 and PCSrc=10; JR -> state 12 with JR=1 and PCSrc=11.
REQ-037 Opcode 111111 -> illegal=1 in DECODE, then FETCH; no write enable asserted.
REQ-038 reset asserted between edges while in MEM_WR -> state=0 and MemWrite=0 immediately.
